// File: rtl/lane_geometry_engine_if.sv
// Request/response handshake bundle for the lane geometry engine.
// master = drawing logic issuing requests, slave = the engine.
interface lane_geometry_engine_if #(
    parameter int COORD_W = 10,
    parameter int LANE_W  = 3
);
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_y;
    logic [LANE_W-1:0]  req_lane;
    logic               resp_valid;
    logic               resp_ready;
    logic [COORD_W-1:0] resp_x;
    logic [COORD_W-1:0] resp_width;
    logic               resp_visible;

    modport master (
        output req_valid, req_y, req_lane, resp_ready,
        input  req_ready, resp_valid, resp_x, resp_width, resp_visible
    );

    modport slave (
        input  req_valid, req_y, req_lane, resp_ready,
        output req_ready, resp_valid, resp_x, resp_width, resp_visible
    );
endinterface

// File: rtl/lane_geometry_engine.sv
// Perspective lane geometry: width grows linearly per scanline (serial shift-add),
// left edge is reached by stepping whole lane widths out from the centre line.
module lane_geometry_engine #(
    parameter int NUM_LANES    = 4,
    parameter int COORD_W      = 10,
    parameter int FRAC_W       = 8,
    parameter int CENTER_X     = 317,
    parameter int Y_TOP        = 0,
    parameter int Y_BOT        = 479,
    parameter int TOP_SPACING  = 40,
    parameter int SPACING_STEP = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lane_geometry_engine_if.slave bus
);
    localparam int     LANE_W  = $clog2(NUM_LANES) + 1;
    localparam longint ACC_MAX = (longint'(TOP_SPACING) << FRAC_W)
                               + longint'(SPACING_STEP) * ((longint'(1) << COORD_W) - 1);
    localparam int     ACC_W   = $clog2(ACC_MAX + 1);
    localparam int     WID_W   = ACC_W - FRAC_W;
    localparam int     XW      = COORD_W + 2;
    localparam int     SW      = ((XW > WID_W) ? XW : WID_W) + 1;
    localparam int     YW      = COORD_W + 1;
    localparam int     CNT_W   = $clog2(COORD_W + 1);

    localparam logic [LANE_W-1:0]    HALF      = LANE_W'(NUM_LANES / 2);
    localparam logic [LANE_W-1:0]    NL        = LANE_W'(NUM_LANES);
    localparam logic [YW-1:0]        YT        = YW'(Y_TOP);
    localparam logic [YW-1:0]        YB        = YW'(Y_BOT);
    localparam logic [ACC_W-1:0]     ACC_INIT  = ACC_W'(longint'(TOP_SPACING) << FRAC_W);
    localparam logic [ACC_W-1:0]     STEP_INIT = ACC_W'(SPACING_STEP);
    localparam logic signed [XW-1:0] CX        = XW'(CENTER_X);
    localparam logic [SW-1:0]        MAXC      = SW'((longint'(1) << COORD_W) - 1);
    localparam logic [CNT_W-1:0]     BITS_M1   = CNT_W'(COORD_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, LANE, DONE} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] w;
        logic               vis;
    } res_t;

    state_t                 state, state_nxt;
    logic [COORD_W-1:0]     mreg;
    logic [ACC_W-1:0]       acc, stp, acc_add;
    logic [CNT_W-1:0]       bcnt;
    logic [LANE_W-1:0]      lcnt;
    logic                   add_r;
    logic [WID_W-1:0]       width_r, w_cand;
    logic signed [XW-1:0]   acc_x, x_step, x_cand, w_x;
    logic [SW-1:0]          w_ext, sum;
    logic [YW-1:0]          ydiff;
    logic                   oor, vis, load;
    res_t                   res, res_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req_valid) state_nxt = oor ? DONE : MUL;
            MUL:     if (bcnt == '0) state_nxt = (lcnt == '0) ? DONE : LANE;
            LANE:    if (lcnt == LANE_W'(1)) state_nxt = DONE;
            DONE:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Candidate result for whichever cycle enters DONE: MUL exit uses the fresh
    // width at the centre line, LANE uses the stepped edge.
    always_comb begin
        ydiff   = {1'b0, bus.req_y} - YT;
        oor     = ydiff[COORD_W] | ({1'b0, bus.req_y} > YB) | (bus.req_lane >= NL);
        acc_add = acc + (mreg[0] ? stp : '0);
        w_cand  = (state == MUL) ? acc_add[ACC_W-1:FRAC_W] : width_r;
        w_ext   = SW'(w_cand);
        w_x     = XW'(w_cand);
        x_step  = add_r ? acc_x + w_x : acc_x - w_x;
        x_cand  = (state == MUL) ? CX : x_step;
        sum     = SW'(x_cand[XW-2:0]) + w_ext;
        vis     = ~x_cand[XW-1] & ~(|w_ext[SW-1:COORD_W]) & (w_cand != '0) & ~(sum > MAXC);
        res_nxt = '0;
        if (vis && state != IDLE) begin
            res_nxt.x   = x_cand[COORD_W-1:0];
            res_nxt.w   = w_ext[COORD_W-1:0];
            res_nxt.vis = 1'b1;
        end
        load    = (state_nxt == DONE) && (state != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreg    <= '0;
            acc     <= '0;
            stp     <= '0;
            bcnt    <= '0;
            lcnt    <= '0;
            add_r   <= 1'b0;
            width_r <= '0;
            acc_x   <= '0;
            res     <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    mreg  <= ydiff[COORD_W-1:0];
                    acc   <= ACC_INIT;
                    stp   <= STEP_INIT;
                    bcnt  <= BITS_M1;
                    add_r <= (bus.req_lane >= HALF);
                    lcnt  <= (bus.req_lane >= HALF) ? bus.req_lane - HALF : HALF - bus.req_lane;
                end
                MUL: begin
                    acc  <= acc_add;
                    mreg <= mreg >> 1;
                    stp  <= stp << 1;
                    bcnt <= bcnt - CNT_W'(1);
                    if (bcnt == '0) begin
                        width_r <= acc_add[ACC_W-1:FRAC_W];
                        acc_x   <= CX;
                    end
                end
                LANE: begin
                    acc_x <= x_step;
                    lcnt  <= lcnt - LANE_W'(1);
                end
                default: ;
            endcase
            if (load) res <= res_nxt;
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = (state == DONE);
    assign bus.resp_x       = res.x;
    assign bus.resp_width   = res.w;
    assign bus.resp_visible = res.vis;
endmodule

// File: doc/lane_geometry_engine.md
# lane_geometry_engine

Parametrised perspective-lane geometry unit for the note highway renderer. Given a scanline y and a lane index, it computes the lane's left edge x and pixel width on a trapezoidal highway. Geometry comes from arithmetic (linear spacing growth per line) instead of per-boundary lookup ROMs. It replaces the fixed 4-lane combinational lookup path; note/block drawing logic issues requests through a valid/ready handshake and gets registered results back.

## Interface
- NUM_LANES, 4: lane count; even, 2..16.
- COORD_W, 10: pixel coordinate width (x and y).
- FRAC_W, 8: fractional bits of the spacing accumulator.
- CENTER_X, 317: x of the highway centre line; lane NUM_LANES/2 starts here.
- Y_TOP, 0: first visible highway line.
- Y_BOT, 479: last visible highway line.
- TOP_SPACING, 40: lane width in pixels at Y_TOP.
- SPACING_STEP, 48: width growth per line, unsigned fixed point with FRAC_W fractional bits (48 = 0.1875 px/line).
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_y  in  COORD_W  scanline.
- req_lane  in  clog2(NUM_LANES)+1  lane index.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_x  out  COORD_W  lane left edge.
- resp_width  out  COORD_W  lane width.
- resp_visible  out  1  result is drawable.

## Operation
- States: IDLE, MUL, LANE, DONE.
- IDLE: req_ready=1. On req_valid, capture req_y and req_lane.
  - If y<Y_TOP, y>Y_BOT, or lane>=NUM_LANES: go to DONE with visible=0, x=0, width=0.
  - Otherwise go to MUL.
- MUL: shift-add multiply SPACING_STEP*(y-Y_TOP), one multiplier bit per cycle, exactly COORD_W cycles. Accumulator is initialised to TOP_SPACING<<FRAC_W and must be wide enough that it never overflows. On exit: width = accumulator>>FRAC_W (truncate), and acc_x = CENTER_X in a signed COORD_W+2 register.
- LANE: repeated add/subtract, one step per cycle, for |lane-NUM_LANES/2| steps.
  - lane>=NUM_LANES/2: add width each step.
  - lane<NUM_LANES/2: subtract width each step.
  - Zero steps: skip LANE and go straight from MUL to DONE.
- Result: x_left = CENTER_X + (lane-NUM_LANES/2)*width. Adjacent lanes tile exactly: x(k+1) = x(k) + width.
- DONE: resp_valid=1. visible=1 unless any of:
  - acc_x<0,
  - acc_x+width > 2^COORD_W-1,
  - width==0 or width > 2^COORD_W-1.
  - When not visible, x and width read 0.
- resp_x, resp_width and resp_visible stay stable while resp_valid=1 and resp_ready=0. Transition DONE->IDLE happens on resp_ready.
- req_ready=0 in MUL, LANE and DONE. Requests are not queued; req_* is ignored outside IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, req_ready=1, resp_valid=0, resp_x=0, resp_width=0, resp_visible=0. All internal accumulators and counters are cleared.
- Accept happens in cycle 0 (req_valid & req_ready).
- Out-of-range request: resp_valid asserts at cycle 1.
- In-range request: resp_valid asserts at cycle 1 + COORD_W + |lane-NUM_LANES/2|. With defaults this is 11 to 13 cycles.
- resp_valid & resp_ready at cycle n: resp_valid=0 and req_ready=1 at n+1. The next accept is possible at n+1, not in the same cycle.
- Reset asserted mid-operation: the in-flight request is dropped, with no response.
- The result registers update only on entry to DONE.

## Test plan
- Reset, then idle: req_ready=1, resp_valid=0, all outputs 0. Assert Reset_n=0 during MUL: outputs return to reset values immediately, and no response follows release.
- y=0, lane 0 → x=237, width=40, visible=1, latency 13. y=0, lane 3 → x=357, width=40, latency 12.
- y=256, lanes 1 and 2 → widths 88; x=229 (latency 12) and x=317 (latency 11). Confirms tiling: 229+88 = 317.
- y=479, lane 0 → width=129 (33232>>8, truncated), x=59. Lane 3 → x=446.
- y=480 and lane=4 (each with y=100) → visible=0, x=0, width=0, resp_valid at cycle 1.
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_* is stable and req_ready=0; a req_valid pulse during the stall is ignored.
  - Release: a back-to-back request is accepted in the cycle after the handshake.
